// File: rtl/mv_pattern_pkg.sv
// Shared definitions for the 64x64 checkerboard pattern source and checker.
package mv_pattern_pkg;

  localparam int unsigned CHK_TILE_BIT = 6;
  localparam logic [7:0]  PIX_ON       = 8'hFF;
  localparam logic [7:0]  PIX_OFF      = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    CHECK
  } chk_state_e;

  function automatic logic [7:0] chk_pixel(input logic [11:0] x, input logic [11:0] y);
    return (x[CHK_TILE_BIT] ^ y[CHK_TILE_BIT]) ? PIX_ON : PIX_OFF;
  endfunction

endpackage

// File: rtl/video_xy_tracker.sv
// Registers vs/de once and rebuilds pixel coordinates, frame start, line end and line length.
module video_xy_tracker #(
  parameter logic VS_POL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        vs_i,
  input  logic        de_i,
  output logic        fs_o,
  output logic        line_end_o,
  output logic        de_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic [15:0] line_len_o
);

  logic        vs_q, vs_qq, de_q, de_qq;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [15:0] len_q, len_d;
  logic        de_rise;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
      de_q  <= 1'b0;
      de_qq <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      len_q <= '0;
    end else begin
      vs_q  <= vs_i;
      vs_qq <= vs_q;
      de_q  <= de_i;
      de_qq <= de_q;
      x_q   <= x_d;
      y_q   <= y_d;
      len_q <= len_d;
    end
  end

  always_comb begin
    fs_o       = (vs_q == VS_POL) && (vs_qq != VS_POL);
    de_rise    = de_q && !de_qq;
    line_end_o = !de_q && de_qq;
    de_o       = de_q;
    x_o        = de_rise ? '0 : x_q;
    // Frame start overrides the line counter, even with de still high.
    y_o        = fs_o ? '0 : y_q;
    line_len_o = len_q;
    x_d        = x_q;
    len_d      = len_q;
    y_d        = y_o;
    if (de_q) begin
      x_d   = x_o + 12'd1;
      len_d = (de_rise ? 16'd0 : len_q) + 16'd1;
    end
    if (line_end_o && !fs_o) y_d = y_q + 12'd1;
  end

endmodule

// File: rtl/mv_pattern3_checker.sv
// Checkerboard stream checker: per-pixel compare, resolution measurement, lock FSM.
// Optional CHK_FIRST_ERR_CAPTURE_EN adds first-error coordinate/value capture ports.
module mv_pattern3_checker
  import mv_pattern_pkg::*;
#(
  parameter logic        VS_POL    = 1'b1,
  parameter int unsigned ERR_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          hactive,
  input  logic [15:0]          vactive,
  input  logic                 vs,
  input  logic                 de,
  input  logic [7:0]           rgb_r,
  input  logic [7:0]           rgb_g,
  input  logic [7:0]           rgb_b,
  output logic                 locked,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [15:0]          meas_hactive,
  output logic [15:0]          meas_vactive,
  output logic [15:0]          frame_cnt,
  output logic [ERR_CNT_W-1:0] pix_err_cnt
`ifdef CHK_FIRST_ERR_CAPTURE_EN
  ,
  output logic [11:0]          first_err_x,
  output logic [11:0]          first_err_y,
  output logic [23:0]          first_err_rgb,
  output logic                 first_err_vld
`endif
);

  chk_state_e           state_q, state_d;
  logic                 locked_q, locked_d, done_q, done_d, ferr_q, ferr_d;
  logic                 err_acc_q, err_acc_d;
  logic [15:0]          meas_h_q, meas_h_d, meas_v_q, meas_v_d;
  logic [15:0]          fcnt_q, fcnt_d, line_cnt_q, line_cnt_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]          rgb_q;

  logic                 fs, line_end, de_t;
  logic [11:0]          x, y;
  logic [15:0]          line_len, lines_closing;
  logic [7:0]           exp_pix;
  logic                 pix_err, line_err, frame_bad;

  video_xy_tracker #(.VS_POL(VS_POL)) u_xy (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .vs_i       (vs),
    .de_i       (de),
    .fs_o       (fs),
    .line_end_o (line_end),
    .de_o       (de_t),
    .x_o        (x),
    .y_o        (y),
    .line_len_o (line_len)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      locked_q   <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      err_acc_q  <= 1'b0;
      meas_h_q   <= '0;
      meas_v_q   <= '0;
      fcnt_q     <= '0;
      line_cnt_q <= '0;
      cnt_q      <= '0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      locked_q   <= locked_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      err_acc_q  <= err_acc_d;
      meas_h_q   <= meas_h_d;
      meas_v_q   <= meas_v_d;
      fcnt_q     <= fcnt_d;
      line_cnt_q <= line_cnt_d;
      cnt_q      <= cnt_d;
      rgb_q      <= {rgb_r, rgb_g, rgb_b};
    end
  end

  always_comb begin
    exp_pix       = chk_pixel(x, y);
    pix_err       = (state_q == CHECK) && de_t && (rgb_q != {3{exp_pix}});
    line_err      = line_end && (line_len != hactive);
    lines_closing = line_cnt_q + {15'd0, line_end};
    // Errors landing on the fs cycle belong to the frame being closed.
    frame_bad     = err_acc_q || pix_err || line_err || (lines_closing != vactive) || de_t;

    state_d    = state_q;
    locked_d   = locked_q;
    done_d     = 1'b0;
    ferr_d     = ferr_q;
    err_acc_d  = err_acc_q;
    meas_h_d   = meas_h_q;
    meas_v_d   = meas_v_q;
    fcnt_d     = fcnt_q;
    line_cnt_d = line_cnt_q;
    cnt_d      = cnt_q;

    if (line_end) line_cnt_d = line_cnt_q + 16'd1;
    if (line_end && state_q != IDLE) meas_h_d = line_len;
    if (state_q == CHECK) err_acc_d = err_acc_q || pix_err || line_err;
    if (pix_err && cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);

    if (fs) begin
      line_cnt_d = '0;
      err_acc_d  = 1'b0;
      unique case (state_q)
        IDLE:  state_d = ALIGN;
        ALIGN: begin
          meas_v_d = lines_closing;
          state_d  = CHECK;
        end
        CHECK: begin
          meas_v_d = lines_closing;
          done_d   = 1'b1;
          ferr_d   = frame_bad;
          fcnt_d   = fcnt_q + 16'd1;
          locked_d = !frame_bad;
          if (frame_bad) state_d = ALIGN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef CHK_FIRST_ERR_CAPTURE_EN
  logic        fe_vld_q;
  logic [11:0] fe_x_q, fe_y_q;
  logic [23:0] fe_rgb_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fe_vld_q <= 1'b0;
      fe_x_q   <= '0;
      fe_y_q   <= '0;
      fe_rgb_q <= '0;
    end else if (pix_err && !fe_vld_q) begin
      fe_vld_q <= 1'b1;
      fe_x_q   <= x;
      fe_y_q   <= y;
      fe_rgb_q <= rgb_q;
    end
  end

  assign first_err_x   = fe_x_q;
  assign first_err_y   = fe_y_q;
  assign first_err_rgb = fe_rgb_q;
  assign first_err_vld = fe_vld_q;
`endif

  assign locked       = locked_q;
  assign frame_done   = done_q;
  assign frame_err    = ferr_q;
  assign meas_hactive = meas_h_q;
  assign meas_vactive = meas_v_q;
  assign frame_cnt    = fcnt_q;
  assign pix_err_cnt  = cnt_q;

endmodule

// File: tb/tb_mv_pattern3_checker.sv
// Randomized checkerboard frames against a frame-level reference model; a second
// instance with a 4-bit error counter covers saturation.
module tb_mv_pattern3_checker;

  localparam int H = 68;
  localparam int V = 66;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hactive = 16'(H);
  logic [15:0] vactive = 16'(V);
  logic        vs = 1'b0, de = 1'b0;
  logic [7:0]  rgb_r = '0, rgb_g = '0, rgb_b = '0;

  logic        locked, frame_done, frame_err;
  logic [15:0] meas_hactive, meas_vactive, frame_cnt;
  logic [31:0] pix_err_cnt;
  logic        s_locked, s_frame_done, s_frame_err;
  logic [15:0] s_meas_h, s_meas_v, s_frame_cnt;
  logic [3:0]  s_pix_err_cnt;
`ifdef CHK_FIRST_ERR_CAPTURE_EN
  logic [11:0] fe_x, fe_y, s_fe_x, s_fe_y;
  logic [23:0] fe_rgb, s_fe_rgb;
  logic        fe_vld, s_fe_vld;
`endif

  mv_pattern3_checker #(.VS_POL(1'b1), .ERR_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .hactive(hactive), .vactive(vactive),
    .vs(vs), .de(de), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .locked(locked), .frame_done(frame_done), .frame_err(frame_err),
    .meas_hactive(meas_hactive), .meas_vactive(meas_vactive),
    .frame_cnt(frame_cnt), .pix_err_cnt(pix_err_cnt)
`ifdef CHK_FIRST_ERR_CAPTURE_EN
    , .first_err_x(fe_x), .first_err_y(fe_y), .first_err_rgb(fe_rgb), .first_err_vld(fe_vld)
`endif
  );

  mv_pattern3_checker #(.VS_POL(1'b1), .ERR_CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .hactive(hactive), .vactive(vactive),
    .vs(vs), .de(de), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .locked(s_locked), .frame_done(s_frame_done), .frame_err(s_frame_err),
    .meas_hactive(s_meas_h), .meas_vactive(s_meas_v),
    .frame_cnt(s_frame_cnt), .pix_err_cnt(s_pix_err_cnt)
`ifdef CHK_FIRST_ERR_CAPTURE_EN
    , .first_err_x(s_fe_x), .first_err_y(s_fe_y), .first_err_rgb(s_fe_rgb), .first_err_vld(s_fe_vld)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame-level model: phase 0 = waiting, 1 = measuring, 2 = checking.
  int phase = 0;
  int m_locked = 0, m_fcnt = 0, m_pix = 0, m_meas_h = 0, m_meas_v = 0;
  int fr_pix = 0, fr_lines = 0;
  bit fr_bad = 1'b0;
  logic [23:0] inj [int];

  task automatic model_reset();
    phase = 0; m_locked = 0; m_fcnt = 0; m_pix = 0; m_meas_h = 0; m_meas_v = 0;
    fr_pix = 0; fr_lines = 0; fr_bad = 1'b0;
  endtask

  task automatic drive(input logic v_i, input logic d_i, input logic [23:0] px);
    @(posedge clk); #1;
    vs = v_i; de = d_i; {rgb_r, rgb_g, rgb_b} = px;
  endtask

  task automatic send_vs();
    logic [3:0] done_seen;
    logic       err_at;
    bit         exp_done, exp_err;
    int         sat;
    exp_done  = (phase == 2);
    exp_err   = fr_bad || (fr_pix != 0) || (fr_lines != V);
    done_seen = '0;
    err_at    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 24'h0);
      @(negedge clk);
      done_seen[i] = frame_done;
      if (i == 2) err_at = frame_err;
    end
    total++;
    if (done_seen !== (exp_done ? 4'b0100 : 4'b0000)) begin
      bad++; $display("FAIL frame_done_pulse got=%b exp=%b", done_seen, exp_done ? 4'b0100 : 4'b0000);
    end
    if (exp_done) begin
      total++;
      if (err_at !== exp_err) begin
        bad++; $display("FAIL frame_err got=%0b exp=%0b", err_at, exp_err);
      end
    end
    if (phase != 0) m_meas_v = fr_lines;
    if (phase == 2) begin
      m_fcnt++;
      m_pix   += fr_pix;
      m_locked = exp_err ? 0 : 1;
      if (exp_err) phase = 1;
    end else if (phase == 1) phase = 2;
    else phase = 1;
    fr_pix = 0; fr_lines = 0; fr_bad = 1'b0;
    sat = (m_pix > 15) ? 15 : m_pix;
    total++;
    if (locked !== 1'(m_locked)) begin
      bad++; $display("FAIL locked got=%0b exp=%0d", locked, m_locked);
    end
    total++;
    if (frame_cnt !== 16'(m_fcnt)) begin
      bad++; $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, m_fcnt);
    end
    total++;
    if (pix_err_cnt !== 32'(m_pix)) begin
      bad++; $display("FAIL pix_err_cnt got=%0d exp=%0d", pix_err_cnt, m_pix);
    end
    total++;
    if (s_pix_err_cnt !== 4'(sat)) begin
      bad++; $display("FAIL pix_err_cnt_sat got=%0d exp=%0d", s_pix_err_cnt, sat);
    end
    total++;
    if (meas_vactive !== 16'(m_meas_v)) begin
      bad++; $display("FAIL meas_vactive got=%0d exp=%0d", meas_vactive, m_meas_v);
    end
    total++;
    if (meas_hactive !== 16'(m_meas_h)) begin
      bad++; $display("FAIL meas_hactive got=%0d exp=%0d", meas_hactive, m_meas_h);
    end
  endtask

  task automatic send_lines(input int nlines, input int short_y, input int stop_y);
    repeat ($urandom_range(2, 4)) drive(1'b0, 1'b0, 24'h0);
    for (int y = 0; y < nlines && y < stop_y; y++) begin
      int          len;
      logic [23:0] ev, pv;
      len = (y == short_y) ? H - 1 : H;
      for (int x = 0; x < len; x++) begin
        ev = ((((x >> 6) ^ (y >> 6)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
        pv = inj.exists(y * 4096 + x) ? inj[y * 4096 + x] : ev;
        if (phase == 2 && pv != ev) fr_pix++;
        drive(1'b0, 1'b1, pv);
      end
      fr_lines++;
      if (phase == 2 && len != H) fr_bad = 1'b1;
      if (phase != 0) m_meas_h = len;
      repeat ($urandom_range(3, 5)) drive(1'b0, 1'b0, 24'h0);
      if (y == short_y) begin
        @(negedge clk);
        total++;
        if (meas_hactive !== 16'(len)) begin
          bad++; $display("FAIL meas_hactive_short got=%0d exp=%0d", meas_hactive, len);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({locked, frame_done, frame_err, meas_hactive, meas_vactive, frame_cnt} !== 51'd0) begin
      bad++; $display("FAIL %s_outputs got=%0b%0b%0b h=%0d v=%0d f=%0d exp=0", tag,
                      locked, frame_done, frame_err, meas_hactive, meas_vactive, frame_cnt);
    end
    total++;
    if (pix_err_cnt !== 32'd0 || s_pix_err_cnt !== 4'd0) begin
      bad++; $display("FAIL %s_pix_err_cnt got=%0d/%0d exp=0", tag, pix_err_cnt, s_pix_err_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) drive(1'b0, 1'b0, 24'h0);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_clean_lock();
    inj.delete();
    send_vs(); send_lines(V, -1, V);
    send_vs(); send_lines(V, -1, V);
    send_vs();
  endtask

  task automatic test_pixel_err();
    inj.delete();
    inj[0 * 4096 + 64] = 24'h000000;
    send_lines(V, -1, V);
    send_vs();
`ifdef CHK_FIRST_ERR_CAPTURE_EN
    total++;
    if (fe_vld !== 1'b1 || fe_x !== 12'd64 || fe_y !== 12'd0 || fe_rgb !== 24'h0) begin
      bad++; $display("FAIL first_err got=%0b x=%0d y=%0d rgb=%h exp=1 x=64 y=0 rgb=0",
                      fe_vld, fe_x, fe_y, fe_rgb);
    end
`endif
    inj.delete();
  endtask

  task automatic test_short_line();
    send_lines(V, -1, V);
    send_vs();
    send_lines(V, $urandom_range(0, V - 1), V);
    send_vs();
  endtask

  task automatic test_short_frame();
    send_lines(V, -1, V);
    send_vs();
    send_lines(V - 1, -1, V);
    send_vs();
    send_lines(V, -1, V);
    send_vs();
    send_lines(V, -1, V);
    send_vs();
  endtask

  task automatic test_random_errors();
    int n, k;
    inj.delete();
    n = $urandom_range(20, 26);
    while (inj.num() < n) begin
      k = $urandom_range(0, V - 1) * 4096 + $urandom_range(0, H - 1);
      if (!inj.exists(k)) inj[k] = 24'($urandom);
    end
    send_lines(V, -1, V);
    send_vs();
    inj.delete();
  endtask

  task automatic test_reset_mid();
    send_lines(V, -1, 30);
    repeat (10) drive(1'b0, 1'b1, 24'hFFFFFF);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (5) drive(1'b0, 1'b1, 24'h123456);
    @(negedge clk);
    check_all_zero("reset_mid");
    @(posedge clk); #1 rst_n = 1'b1; de = 1'b0;
    model_reset();
    repeat (6) drive(1'b0, 1'b0, 24'h0);
    send_vs(); send_lines(V, -1, V);
    send_vs(); send_lines(V, -1, V);
    send_vs();
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_pixel_err();
    test_short_line();
    test_short_frame();
    test_random_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
